// File: rtl/resp_buffer_l2.sv
// resp_buffer_l2 : credit-gated response FIFO behind the L2 response fan-in tree.
// Optional same-cycle bypass of an empty FIFO: define RESP_BUF_BYPASS_EN.
`default_nettype none

module resp_buffer_l2 #(
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_NUM   = DATA_WIDTH / 8,
  parameter int TAG_WIDTH  = BYTE_NUM,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_gnt_o,
  output logic                  req_o,
  input  logic                  req_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic [TAG_WIDTH-1:0]  data_r_rtag_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic [TAG_WIDTH-1:0]  resp_rtag_o,
  input  logic                  resp_ready_i,
  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic                  err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + TAG_WIDTH;
  localparam logic [CNT_WIDTH-1:0] C_DEPTH = CNT_WIDTH'(DEPTH);

  logic [EW-1:0]        mem_q [DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] outstanding_q, outstanding_d;
  logic                 err_q, err_d;

  logic                 empty, full;
  logic [CNT_WIDTH-1:0] occupancy;
  logic                 pop, fifo_pop, fifo_push, bypass_take;
  logic [EW-1:0]        head;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign occupancy = CNT_WIDTH'(wptr_q - rptr_q);
  assign head      = mem_q[rptr_q[AW-1:0]];

  assign req_o     = req_valid_i & (outstanding_q < C_DEPTH);
  assign req_gnt_o = req_o & req_gnt_i;

`ifdef RESP_BUF_BYPASS_EN
  // An empty FIFO forwards the tree response straight through; if the master
  // takes it this cycle, push and pop cancel and nothing is written.
  assign bypass_take = empty & data_r_valid_i & resp_ready_i;

  always_comb begin
    resp_valid_o = !empty | data_r_valid_i;
    resp_rdata_o = '0;
    resp_rtag_o  = '0;
    if (!empty) begin
      resp_rdata_o = head[EW-1:TAG_WIDTH];
      resp_rtag_o  = head[TAG_WIDTH-1:0];
    end else if (data_r_valid_i) begin
      resp_rdata_o = data_r_rdata_i;
      resp_rtag_o  = data_r_rtag_i;
    end
  end
`else
  assign bypass_take = 1'b0;

  always_comb begin
    resp_valid_o = !empty;
    resp_rdata_o = '0;
    resp_rtag_o  = '0;
    if (!empty) begin
      resp_rdata_o = head[EW-1:TAG_WIDTH];
      resp_rtag_o  = head[TAG_WIDTH-1:0];
    end
  end
`endif

  assign pop       = resp_valid_o & resp_ready_i;
  assign fifo_pop  = pop & !empty;
  assign fifo_push = data_r_valid_i & !bypass_take & (!full | fifo_pop);

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;

    if (fifo_push) wptr_d = wptr_q + PW'(1);
    if (fifo_pop)  rptr_d = rptr_q + PW'(1);

    case ({req_gnt_o, pop})
      2'b10: begin
        if (outstanding_q == C_DEPTH) err_d = 1'b1;
        else                          outstanding_d = outstanding_q + CNT_WIDTH'(1);
      end
      2'b01: begin
        if (outstanding_q == '0) err_d = 1'b1;
        else                     outstanding_d = outstanding_q - CNT_WIDTH'(1);
      end
      default: ;
    endcase

    // Overflow drops the response; a response with nothing in flight is spurious.
    if (data_r_valid_i && full && !fifo_pop)            err_d = 1'b1;
    if (data_r_valid_i && (outstanding_q <= occupancy)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wptr_q[AW-1:0]] <= {data_r_rdata_i, data_r_rtag_i};
  end

  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_resp_buffer_l2.sv
// tb_resp_buffer_l2 : directed self-checking bench for resp_buffer_l2 (DEPTH=4).
`default_nettype none

module tb_resp_buffer_l2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_gnt_o, req_o, req_gnt_i;
  logic        data_r_valid_i;
  logic [63:0] data_r_rdata_i;
  logic [7:0]  data_r_rtag_i;
  logic        resp_valid_o;
  logic [63:0] resp_rdata_o;
  logic [7:0]  resp_rtag_o;
  logic        resp_ready_i;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  resp_buffer_l2 dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_gnt_o     (req_gnt_o),
    .req_o         (req_o),
    .req_gnt_i     (req_gnt_i),
    .data_r_valid_i(data_r_valid_i),
    .data_r_rdata_i(data_r_rdata_i),
    .data_r_rtag_i (data_r_rtag_i),
    .resp_valid_o  (resp_valid_o),
    .resp_rdata_o  (resp_rdata_o),
    .resp_rtag_o   (resp_rtag_o),
    .resp_ready_i  (resp_ready_i),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change at the falling edge; checks follow 1ns later.
  task automatic drive(input logic rv, input logic gi, input logic dv,
                       input logic [63:0] d, input logic [7:0] t, input logic rdy);
    req_valid_i    = rv;
    req_gnt_i      = gi;
    data_r_valid_i = dv;
    data_r_rdata_i = d;
    data_r_rtag_i  = t;
    resp_ready_i   = rdy;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 64'h0, 8'h0, 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(resp_valid_o), 64'h0);
    chk("rst_out",   64'(outstanding_o), 64'h0);
    chk("rst_err",   64'(err_o), 64'h0);
    chk("rst_req",   64'(req_o), 64'h0);
    chk("rst_rdata", resp_rdata_o, 64'h0);
    chk("rst_rtag",  64'(resp_rtag_o), 64'h0);

    // Credit limit: six cycles of request, only four granted.
    for (int i = 0; i < 6; i++) begin
      step();
      drive(1, 1, 0, 64'h0, 8'h0, 0);
      chk($sformatf("credit_gnt%0d", i), 64'(req_gnt_o), (i < 4) ? 64'h1 : 64'h0);
      chk($sformatf("credit_req%0d", i), 64'(req_o),     (i < 4) ? 64'h1 : 64'h0);
    end
    step();
    drive(0, 0, 0, 64'h0, 8'h0, 0);
    chk("credit_out", 64'(outstanding_o), 64'h4);

    // Fill with tags 1..4 while the master stalls.
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 1, 64'h9 + 64'(k), 8'(k), 0);
      if (k > 1) chk($sformatf("fill_head%0d", k), 64'(resp_rtag_o), 64'h1);
      step();
    end
    drive(0, 0, 0, 64'h0, 8'h0, 0);
    chk("full_valid", 64'(resp_valid_o), 64'h1);
    chk("full_tag",   64'(resp_rtag_o), 64'h1);
    chk("full_data",  resp_rdata_o, 64'hA);
    chk("full_out",   64'(outstanding_o), 64'h4);
    step();
    drive(0, 0, 0, 64'h0, 8'h0, 0);
    chk("stall_tag",  64'(resp_rtag_o), 64'h1);
    chk("stall_err",  64'(err_o), 64'h0);

    // Drain with a grant and a push overlapping pops.
    drive(0, 0, 0, 64'h0, 8'h0, 1);
    chk("pop1_tag", 64'(resp_rtag_o), 64'h1);
    step();
    drive(1, 1, 0, 64'h0, 8'h0, 1);
    chk("pop2_tag", 64'(resp_rtag_o), 64'h2);
    chk("pop2_gnt", 64'(req_gnt_o), 64'h1);
    chk("pop2_out", 64'(outstanding_o), 64'h3);
    step();
    drive(0, 0, 1, 64'hE, 8'h05, 1);
    chk("pop3_out", 64'(outstanding_o), 64'h3);
    chk("pop3_tag", 64'(resp_rtag_o), 64'h3);
    chk("pop3_data", resp_rdata_o, 64'hC);
    step();
    drive(0, 0, 0, 64'h0, 8'h0, 1);
    chk("pop4_tag", 64'(resp_rtag_o), 64'h4);
    chk("pop4_data", resp_rdata_o, 64'hD);
    chk("pop4_out", 64'(outstanding_o), 64'h2);
    step();
    drive(0, 0, 0, 64'h0, 8'h0, 1);
    chk("pop5_tag", 64'(resp_rtag_o), 64'h5);
    chk("pop5_data", resp_rdata_o, 64'hE);
    step();
    drive(0, 0, 0, 64'h0, 8'h0, 0);
    chk("drain_valid", 64'(resp_valid_o), 64'h0);
    chk("drain_out",   64'(outstanding_o), 64'h0);
    chk("drain_err",   64'(err_o), 64'h0);

    // Single request with the master ready when the response lands.
    drive(1, 1, 0, 64'h0, 8'h0, 0);
    step();
    drive(0, 0, 1, 64'h55, 8'h55, 1);
`ifdef RESP_BUF_BYPASS_EN
    chk("byp_valid0", 64'(resp_valid_o), 64'h1);
    chk("byp_tag0",   64'(resp_rtag_o), 64'h55);
`else
    chk("byp_valid0", 64'(resp_valid_o), 64'h0);
`endif
    step();
    drive(0, 0, 0, 64'h0, 8'h0, 1);
`ifdef RESP_BUF_BYPASS_EN
    chk("byp_valid1", 64'(resp_valid_o), 64'h0);
`else
    chk("byp_valid1", 64'(resp_valid_o), 64'h1);
    chk("byp_data1",  resp_rdata_o, 64'h55);
`endif
    step();
    drive(0, 0, 0, 64'h0, 8'h0, 0);
    chk("byp_out", 64'(outstanding_o), 64'h0);
    chk("byp_err", 64'(err_o), 64'h0);

    // Spurious response with nothing outstanding.
    drive(0, 0, 1, 64'h77, 8'h77, 0);
    step();
    drive(0, 0, 0, 64'h0, 8'h0, 0);
    chk("spur_err",   64'(err_o), 64'h1);
    chk("spur_valid", 64'(resp_valid_o), 64'h1);
    chk("spur_tag",   64'(resp_rtag_o), 64'h77);
    drive(0, 0, 0, 64'h0, 8'h0, 1);
    step();
    drive(0, 0, 0, 64'h0, 8'h0, 0);
    chk("spur_out",   64'(outstanding_o), 64'h0);
    step(); step();
    chk("spur_sticky", 64'(err_o), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("clr_err",   64'(err_o), 64'h0);
    chk("clr_valid", 64'(resp_valid_o), 64'h0);

    // Reset with requests in flight; the late response is spurious.
    drive(1, 1, 0, 64'h0, 8'h0, 0);
    step(); step();
    drive(0, 0, 0, 64'h0, 8'h0, 0);
    chk("mid_out2", 64'(outstanding_o), 64'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_out0", 64'(outstanding_o), 64'h0);
    drive(0, 0, 1, 64'h99, 8'h09, 0);
    step();
    drive(0, 0, 0, 64'h0, 8'h0, 0);
    chk("mid_err", 64'(err_o), 64'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
